regfile: RTL and testbench
==========================

Name: regfile

Overview:
- General-purpose register file for the five-stage core.
- Serves the decode stage's two read requests (enable + address) and accepts the writeback stage's single write per cycle.
- Storage is a 32x32 array with no reset, so it can map to RAM. After reset, a sequential sweep clears registers 1..31.
- Decode must not issue until `ready_o` is high.

Parameters:
- `REG_NUM`, 32, number of architectural registers (power of two).
- `REG_NUM_LOG2`, 5, address width.
- `DATA_W`, 32, register width (matches `RegBus`).

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `we_i`  in  1  writeback write enable.
- `waddr_i`  in  5  writeback destination register.
- `wdata_i`  in  32  writeback data.
- `re1_i`  in  1  read port 1 enable (from decode `reg1_re_o`).
- `raddr1_i`  in  5  read port 1 address.
- `rdata1_o`  out  32  read port 1 data.
- `re2_i`  in  1  read port 2 enable.
- `raddr2_i`  in  5  read port 2 address.
- `rdata2_o`  out  32  read port 2 data.
- `ready_o`  out  1  high once the clear sweep has completed.

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- States: `S_RESET`, `S_INIT`, `S_RUN`. Held in a registered 2-bit state plus a registered 5-bit sweep counter `init_cnt`.
- `rst`=1 at an edge: state <= `S_RESET`, `init_cnt` <= 1, `ready_o` <= 0. Array contents are not reset.
- `S_RESET` -> `S_INIT` on the first edge with `rst`=0.
- `S_INIT`, each edge:
  - mem[`init_cnt`] <= 0; `init_cnt` <= `init_cnt`+1.
  - When `init_cnt`==31: mem[31] <= 0, state <= `S_RUN`, `ready_o` <= 1.
  - The sweep takes exactly 31 cycles in `S_INIT`. `ready_o` rises on the edge that writes register 31.
- External writes during `S_RESET`/`S_INIT` are dropped (no error flag).
- `rst` asserted mid-sweep or in `S_RUN`: return to `S_RESET` at that edge and restart the sweep from 1.
- `S_RUN` write: if `we_i`=1 and `waddr_i`!=0, then mem[`waddr_i`] <= `wdata_i` at the edge. Writes to $0 are discarded.
- Reads are combinational (zero latency). Per port n, priority order:
  1. `rst`=1 or state != `S_RUN` -> 0.
  2. `re_n`=0 -> 0.
  3. `raddr_n`==0 -> 0.
  4. `we_i`=1 and `waddr_i`==`raddr_n` -> `wdata_i` (same-cycle write-through bypass).
  5. Otherwise mem[`raddr_n`].
- Both ports may read the same address, and both may hit the bypass simultaneously.
- Register 0 is never stored; the array location for address 0 is unused.
- Reset values: `rdata1_o`=0, `rdata2_o`=0, `ready_o`=0.

Optional Feature:
- Macro: `REGFILE_DBG_EN`.
- Defined: adds ports `dbg_raddr_i` (in, 5) and `dbg_rdata_o` (out, 32).
  - Combinational, always enabled.
  - No write bypass: returns stored mem contents (0 for address 0; 0 while not in `S_RUN` or while `rst`=1).
  - Used by the simulation trace monitor.
- Not defined: ports absent; no extra logic.

Test Plan:
- Reset sweep: hold `rst`=1 for 3 cycles, release. `ready_o`=0 for 31 edges, rises on the 32nd edge after release. A read of r5 with `re1_i`=1 returns 0.
- Write/read: in `S_RUN`, write r7=0xDEADBEEF. Next cycle `raddr1_i`=7, `re1_i`=1 -> `rdata1_o`=0xDEADBEEF. With `re1_i`=0 -> 0.
- Bypass: same cycle `we_i`=1, `waddr_i`=9, `wdata_i`=0x12345678, `raddr1_i`=`raddr2_i`=9, both enables=1 -> both outputs 0x12345678 that cycle. r9 holds it afterwards.
- $0: write r0=0xFFFFFFFF, then read r0 on both ports, including the same cycle as the write -> 0 both times.
- Write during INIT: assert `we_i` for r3=0xAAAA0000 at sweep cycle 10. After `ready_o`=1, read r3 -> 0.
- Reset mid-sweep: pulse `rst` at sweep cycle 20. `ready_o` stays 0 and rises exactly 32 edges after `rst` falls. With `REGFILE_DBG_EN`, `dbg_rdata_o` for r31 is 0 afterwards.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32x32 GPR file, two combinational read ports with write-through bypass, one write port, post-reset clear sweep.
// Optional trace read port (no bypass) enabled by REGFILE_DBG_EN.
module regfile #(
    parameter int REG_NUM      = 32,
    parameter int REG_NUM_LOG2 = 5,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_i,
    input  logic [REG_NUM_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic                    re1_i,
    input  logic [REG_NUM_LOG2-1:0] raddr1_i,
    output logic [DATA_W-1:0]       rdata1_o,
    input  logic                    re2_i,
    input  logic [REG_NUM_LOG2-1:0] raddr2_i,
    output logic [DATA_W-1:0]       rdata2_o,
`ifdef REGFILE_DBG_EN
    input  logic [REG_NUM_LOG2-1:0] dbg_raddr_i,
    output logic [DATA_W-1:0]       dbg_rdata_o,
`endif
    output logic                    ready_o
);
    typedef enum logic [1:0] {S_RESET, S_INIT, S_RUN} state_t;
    state_t                  state_q, state_d;
    logic [REG_NUM_LOG2-1:0] init_cnt_q, init_cnt_d;
    logic [DATA_W-1:0]       mem [REG_NUM];
    logic                    run, last, mem_we;
    logic [REG_NUM_LOG2-1:0] mem_waddr;
    logic [DATA_W-1:0]       mem_wdata;
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last       = init_cnt_q == REG_NUM_LOG2'(REG_NUM - 1);
        if (state_q == S_RESET) begin
            state_d = S_INIT;
        end else if (state_q == S_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            state_d    = last ? S_RUN : S_INIT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RESET;
            init_cnt_q <= REG_NUM_LOG2'(1);
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end
    // The sweep and the writeback port share the single array write port; writes outside S_RUN are dropped.
    assign run       = !rst && state_q == S_RUN;
    assign mem_we    = !rst && (state_q == S_INIT || (state_q == S_RUN && we_i && waddr_i != '0));
    assign mem_waddr = state_q == S_INIT ? init_cnt_q : waddr_i;
    assign mem_wdata = state_q == S_INIT ? '0 : wdata_i;
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
    assign rdata1_o = (!run || !re1_i || raddr1_i == '0) ? '0 :
                      (we_i && waddr_i == raddr1_i) ? wdata_i : mem[raddr1_i];
    assign rdata2_o = (!run || !re2_i || raddr2_i == '0) ? '0 :
                      (we_i && waddr_i == raddr2_i) ? wdata_i : mem[raddr2_i];
`ifdef REGFILE_DBG_EN
    assign dbg_rdata_o = (!run || dbg_raddr_i == '0) ? '0 : mem[dbg_raddr_i];
`endif
    assign ready_o = state_q == S_RUN;
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: randomized and directed checks of regfile against an array-based reference model.
module tb_regfile;
    logic        clk = 0;
    logic        rst, we, re1, re2, ready_o;
    logic [4:0]  wa, ra1, ra2, dra;
    logic [31:0] wd, rdata1_o, rdata2_o, dbg_rdata_o;
    logic [31:0] mem_m [32];
    int          cyc_m = 0;
    int          n_chk = 0, n_pass = 0, n;
    always #5 clk = ~clk;
    regfile dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(wa), .wdata_i(wd),
        .re1_i(re1), .raddr1_i(ra1), .rdata1_o(rdata1_o),
        .re2_i(re2), .raddr2_i(ra2), .rdata2_o(rdata2_o),
`ifdef REGFILE_DBG_EN
        .dbg_raddr_i(dra), .dbg_rdata_o(dbg_rdata_o),
`endif
        .ready_o(ready_o)
    );
`ifndef REGFILE_DBG_EN
    assign dbg_rdata_o = '0;
`endif
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask
    // Register 1..31 are known zero once 32 edges have passed since reset release.
    function automatic logic ready_m();
        return cyc_m == 32;
    endfunction
    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (rst || !ready_m() || !re || ra == 0) return 0;
        if (we && wa == ra) return wd;
        return mem_m[ra];
    endfunction
    task automatic tick();
        #1;
        check("rd1", rdata1_o, exp_rd(re1, ra1));
        check("rd2", rdata2_o, exp_rd(re2, ra2));
        check("ready", {31'b0, ready_o}, {31'b0, ready_m()});
`ifdef REGFILE_DBG_EN
        check("dbg", dbg_rdata_o, (rst || !ready_m() || dra == 0) ? 32'h0 : mem_m[dra]);
`endif
        @(posedge clk);
        if (!rst && ready_m() && we && wa != 0) mem_m[wa] = wd;
        if (rst) cyc_m = 0;
        else if (cyc_m < 32) begin
            cyc_m++;
            if (cyc_m == 32) foreach (mem_m[i]) mem_m[i] = 0;
        end
        @(negedge clk);
    endtask
    initial begin
        rst = 1; we = 0; wa = 0; wd = 0; re1 = 0; ra1 = 0; re2 = 0; ra2 = 0; dra = 0;
        foreach (mem_m[i]) mem_m[i] = 0;
        @(negedge clk); @(posedge clk); @(negedge clk);
        repeat (3) tick();
        check("rst_rd1", rdata1_o, 0);
        check("rst_ready", {31'b0, ready_o}, 0);
        rst = 0; re1 = 1; ra1 = 5; wa = 3; wd = 32'hAAAA0000;
        n = 0;
        for (int i = 0; i < 40 && ready_o !== 1'b1; i++) begin
            we = cyc_m == 10;
            tick();
            n++;
        end
        we = 0;
        check("sweep_len", n, 32);
        ra1 = 5; #1 check("r5_zero", rdata1_o, 0); tick();
        ra1 = 3; #1 check("r3_init_drop", rdata1_o, 0); tick();
        we = 1; wa = 7; wd = 32'hDEADBEEF; tick();
        we = 0; ra1 = 7; #1 check("r7", rdata1_o, 32'hDEADBEEF); tick();
        re1 = 0; #1 check("r7_noen", rdata1_o, 0); tick();
        we = 1; wa = 9; wd = 32'h12345678; re1 = 1; re2 = 1; ra1 = 9; ra2 = 9;
        #1 check("byp1", rdata1_o, 32'h12345678); check("byp2", rdata2_o, 32'h12345678); tick();
        we = 0; #1 check("r9_held", rdata2_o, 32'h12345678); tick();
        we = 1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0; ra2 = 0;
        #1 check("r0_wr1", rdata1_o, 0); check("r0_wr2", rdata2_o, 0); tick();
        we = 0; #1 check("r0_rd1", rdata1_o, 0); check("r0_rd2", rdata2_o, 0); tick();
        we = 1; wa = 31; wd = 32'hCAFEF00D; tick();
        we = 0; rst = 1; tick();
        rst = 0;
        for (int i = 0; i < 40 && cyc_m < 20; i++) tick();
        rst = 1; tick();
        rst = 0; n = 0;
        for (int i = 0; i < 40 && ready_o !== 1'b1; i++) begin
            tick();
            n++;
        end
        check("midrst_len", n, 32);
        dra = 31; re1 = 1; ra1 = 31;
        #1 check("r31_clr", rdata1_o, 0);
`ifdef REGFILE_DBG_EN
        check("dbg_r31", dbg_rdata_o, 0);
`endif
        tick();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 99) == 0;
            we  = $urandom_range(0, 1);
            wa  = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd  = $urandom;
            re1 = $urandom_range(0, 3) != 0;
            re2 = $urandom_range(0, 3) != 0;
            ra1 = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra2 = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 7));
            dra = 5'($urandom_range(0, 7));
            tick();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
